// File: rtl/rom_load_mem_arbiter.sv
// rom_load_mem_arbiter: shares the single cartridge-memory port between the
// ROM/BIOS loader byte stream (buffered in a small FIFO) and the save-RAM backup
// engine (req/ack handshake). The memory controller acknowledges each request
// after a variable number of cycles.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ld_we, ld_addr, ld_data             loader byte stream, no backpressure
//   sv_req, sv_we, sv_addr, sv_wdata    save request, held until sv_ack
//   sv_ack, sv_rdata                    save completion pulse, read data (held)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata       memory controller port
//   busy, overflow, fifo_level          status
module rom_load_mem_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ld_we,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [7:0]                    ld_data,
  input  logic                          sv_req,
  input  logic                          sv_we,
  input  logic [ADDR_W-1:0]             sv_addr,
  input  logic [7:0]                    sv_wdata,
  output logic                          sv_ack,
  output logic [7:0]                    sv_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_wdata,
  input  logic                          mem_ack,
  input  logic [7:0]                    mem_rdata,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned STRK_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, LD_XFER, SV_XFER} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_d [FIFO_DEPTH];
  logic [7:0]          fifo_data_q [FIFO_DEPTH];
  logic [7:0]          fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                sv_ack_q, sv_ack_d;
  logic [7:0]          sv_rdata_q, sv_rdata_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;

  logic                save_pending;
  logic                fifo_empty;
  logic                fifo_full;
  logic                save_grant;
  logic                ld_grant;
  logic                pop;
  logic                push;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fifo_addr_q <= '{default: '0};
      fifo_data_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sv_ack_q    <= 1'b0;
      sv_rdata_q  <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sv_ack_q    <= sv_ack_d;
      sv_rdata_q  <= sv_rdata_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  // Arbitration, transfer sequencing, streak tracking and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sv_ack_d    = 1'b0;
    sv_rdata_d  = sv_rdata_q;
    overflow_d  = overflow_q;
    save_grant  = 1'b0;
    ld_grant    = 1'b0;
    pop         = 1'b0;

    // The sv_ack cycle still shows the old request level, so it is masked.
    save_pending = sv_req && !sv_ack_q;
    fifo_empty   = (level_q == '0);
    fifo_full    = (level_q == LVL_W'(FIFO_DEPTH));

    case (state_q)
      IDLE: begin
        if (save_pending && (fifo_empty || streak_q == STRK_W'(STARVE_MAX))) begin
          save_grant  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = sv_we;
          mem_addr_d  = sv_addr;
          mem_wdata_d = sv_wdata;
          state_d     = SV_XFER;
        end else if (!fifo_empty) begin
          ld_grant    = 1'b1;
          pop         = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_data_q[rd_ptr_q];
          state_d     = LD_XFER;
        end
      end
      LD_XFER, SV_XFER: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == SV_XFER) begin
            sv_ack_d   = 1'b1;
            sv_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Count loader grants that overtake a waiting save request
    if (!sv_req || save_grant) begin
      streak_d = '0;
    end else if (ld_grant && save_pending && streak_q != STRK_W'(STARVE_MAX)) begin
      streak_d = streak_q + STRK_W'(1);
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs
    push = ld_we && (!fifo_full || pop);
    if (ld_we && !push) begin
      overflow_d = 1'b1;
    end
    if (push) begin
      fifo_addr_d[wr_ptr_q] = ld_addr;
      fifo_data_d[wr_ptr_q] = ld_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    busy_d  = (level_d != '0) || (state_d != IDLE);
  end

  assign sv_ack     = sv_ack_q;
  assign sv_rdata   = sv_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_rom_load_mem_arbiter.sv
// Testbench for rom_load_mem_arbiter: directed scenarios with fixed expected
// values plus a randomized run against a transaction-level reference model
// built from a byte queue and a few counters.
module tb_rom_load_mem_arbiter;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SMAX   = 8;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] SV_ADDR = 22'h2AAAAA;

  logic              clk;
  logic              reset;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              sv_req;
  logic              sv_we;
  logic [ADDR_W-1:0] sv_addr;
  logic [7:0]        sv_wdata;
  logic              sv_ack;
  logic [7:0]        sv_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              overflow;
  logic [LVL_W-1:0]  fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (values the DUT outputs should show after each edge)
  logic [ADDR_W+7:0] m_fifo[$];
  int                m_xfer   = 0;   // 0 none, 1 loader, 2 save
  logic              m_req    = 1'b0;
  logic              m_we     = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [7:0]        m_wdata  = '0;
  logic              m_sv_ack = 1'b0;
  logic [7:0]        m_rdata  = '0;
  logic              m_ovf    = 1'b0;
  int                m_streak = 0;

  rom_load_mem_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .sv_req(sv_req), .sv_we(sv_we), .sv_addr(sv_addr), .sv_wdata(sv_wdata),
    .sv_ack(sv_ack), .sv_rdata(sv_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; the model consumes the inputs present during this cycle.
  task automatic tick();
    logic [ADDR_W+7:0] n_fifo[$];
    int n_xfer, n_streak;
    logic n_req, n_we, n_ack, n_ovf, pend, sgrant, lgrant;
    logic [ADDR_W-1:0] n_addr;
    logic [7:0] n_wdata, n_rdata;
    n_fifo = m_fifo; n_xfer = m_xfer; n_req = m_req; n_we = m_we;
    n_addr = m_addr; n_wdata = m_wdata; n_ack = 1'b0; n_rdata = m_rdata;
    n_ovf = m_ovf; n_streak = m_streak;
    pend = sv_req && !m_sv_ack;
    sgrant = 1'b0; lgrant = 1'b0;
    if (m_xfer == 0) begin
      if (pend && (m_fifo.size() == 0 || m_streak == SMAX)) begin
        sgrant = 1'b1; n_xfer = 2; n_req = 1'b1;
        n_we = sv_we; n_addr = sv_addr; n_wdata = sv_wdata;
      end else if (m_fifo.size() != 0) begin
        lgrant = 1'b1; n_xfer = 1; n_req = 1'b1; n_we = 1'b1;
        {n_addr, n_wdata} = n_fifo.pop_front();
      end
    end else if (mem_ack) begin
      n_xfer = 0; n_req = 1'b0;
      if (m_xfer == 2) begin n_ack = 1'b1; n_rdata = mem_rdata; end
    end
    if (!sv_req || sgrant) n_streak = 0;
    else if (lgrant && pend && m_streak < SMAX) n_streak = m_streak + 1;
    if (ld_we) begin
      if (n_fifo.size() < DEPTH) n_fifo.push_back({ld_addr, ld_data});
      else n_ovf = 1'b1;
    end
    if (reset) begin
      n_fifo.delete(); n_xfer = 0; n_req = 1'b0; n_we = 1'b0; n_addr = '0;
      n_wdata = '0; n_ack = 1'b0; n_rdata = '0; n_ovf = 1'b0; n_streak = 0;
    end
    @(posedge clk);
    #1;
    m_fifo = n_fifo; m_xfer = n_xfer; m_req = n_req; m_we = n_we; m_addr = n_addr;
    m_wdata = n_wdata; m_sv_ack = n_ack; m_rdata = n_rdata; m_ovf = n_ovf; m_streak = n_streak;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    sv_req = 1'b0; sv_we = 1'b0; sv_addr = '0; sv_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; ld_we = 1'b1; sv_req = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hFF;
    tick();
    tick();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    vectors++; if (mem_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    vectors++; if (sv_ack !== 1'b0) begin miscompares++; $display("FAIL rst_sv_ack: got %b expected 0", sv_ack); end
    vectors++; if (sv_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_sv_rdata: got %h expected 0", sv_rdata); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL rst_fifo_level: got %0d expected 0", fifo_level); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    idle_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    ld_we = 1'b1; ld_addr = 22'h000010; ld_data = 8'h4E;
    tick();                                   // now cycle 1
    ld_we = 1'b0;
    vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL sw_level_c1: got %0d expected 1", fifo_level); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sw_req_c1: got %b expected 0", mem_req); end
    tick();                                   // cycle 2
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL sw_req_c2: got %b expected 1", mem_req); end
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %b expected 1", mem_we); end
    vectors++; if (mem_addr !== 22'h000010) begin miscompares++; $display("FAIL sw_addr: got %h expected 000010", mem_addr); end
    vectors++; if (mem_wdata !== 8'h4E) begin miscompares++; $display("FAIL sw_wdata: got %h expected 4e", mem_wdata); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sw_busy_c2: got %b expected 1", busy); end
    tick();                                   // cycle 3
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL sw_req_hold: got %b expected 1", mem_req); end
    tick();                                   // cycle 4
    mem_ack = 1'b1;
    tick();                                   // cycle 5
    mem_ack = 1'b0;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sw_req_c5: got %b expected 0", mem_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sw_busy_c5: got %b expected 0", busy); end
    vectors++; if (sv_ack !== 1'b0) begin miscompares++; $display("FAIL sw_sv_ack: got %b expected 0", sv_ack); end
  endtask

  task automatic test_overflow();
    int stray;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ld_we = 1'b1; ld_addr = ADDR_W'(i); ld_data = 8'(8'h30 + i);
      tick();
    end
    ld_we = 1'b0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    vectors++; if (mem_req !== 1'b1 || mem_addr !== '0) begin miscompares++; $display("FAIL ovf_inflight: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr); end
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 10 && mem_req !== 1'b1; w++) tick();
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ovf_wait_%0d: got req=%b expected 1 within 10 cycles", k, mem_req); end
      vectors++; if (mem_addr !== ADDR_W'(k) || mem_wdata !== 8'(8'h30 + k)) begin miscompares++; $display("FAIL ovf_order_%0d: got addr=%h data=%h expected addr=%h data=%h", k, mem_addr, mem_wdata, ADDR_W'(k), 8'(8'h30 + k)); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    stray = 0;
    for (int w = 0; w < 6; w++) begin
      tick();
      if (mem_req === 1'b1) stray++;
    end
    vectors++; if (stray != 0) begin miscompares++; $display("FAIL ovf_dropped: got %0d extra requests expected 0", stray); end
    vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL ovf_drain: got %0d expected 0", fifo_level); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_save_read();
    do_reset();
    sv_req = 1'b1; sv_we = 1'b0; sv_addr = 22'h3C0012; sv_wdata = 8'h11;
    tick();                                   // cycle 1
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 22'h3C0012) begin miscompares++; $display("FAIL sr_grant: got req=%b we=%b addr=%h expected req=1 we=0 addr=3c0012", mem_req, mem_we, mem_addr); end
    sv_addr = 22'h012345; sv_we = 1'b1;       // late changes must not leak in
    tick();                                   // cycle 2
    vectors++; if (mem_addr !== 22'h3C0012 || mem_we !== 1'b0) begin miscompares++; $display("FAIL sr_stable: got we=%b addr=%h expected we=0 addr=3c0012", mem_we, mem_addr); end
    tick();                                   // cycle 3
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();                                   // cycle 4
    mem_ack = 1'b0; mem_rdata = 8'h5A;
    vectors++; if (sv_ack !== 1'b1 || sv_rdata !== 8'hA5) begin miscompares++; $display("FAIL sr_ack: got ack=%b rdata=%h expected ack=1 rdata=a5", sv_ack, sv_rdata); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sr_req_done: got %b expected 0", mem_req); end
    tick();                                   // cycle 5, sv_req was still high in cycle 4
    vectors++; if (sv_ack !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL sr_no_repeat: got ack=%b req=%b expected 0 0", sv_ack, mem_req); end
    sv_req = 1'b0;
    tick();
    vectors++; if (sv_rdata !== 8'hA5 || mem_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL sr_hold: got rdata=%h req=%b busy=%b expected a5 0 0", sv_rdata, mem_req, busy); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int n, ldc;
    bit got;
    do_reset();
    ldc = 0;
    sv_we = 1'b1; sv_addr = SV_ADDR; sv_wdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      ld_we = 1'b1; ld_addr = ADDR_W'(ldc); ld_data = 8'(ldc); ldc++;
      mem_ack = mem_req;
      tick();
    end
    for (int r = 0; r < 2; r++) begin
      sv_req = 1'b1;
      ld_addr = ADDR_W'(ldc); ld_data = 8'(ldc); ldc++;
      mem_ack = mem_req;
      tick();
      n = 0; got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        mem_ack = mem_req;
        if (mem_req === 1'b1) begin
          if (mem_we === 1'b1 && mem_addr === SV_ADDR) begin
            got = 1'b1;
            vectors++; if (mem_wdata !== 8'h77) begin miscompares++; $display("FAIL st_sv_wdata_%0d: got %h expected 77", r, mem_wdata); end
          end else begin
            n++;
          end
        end
        ld_addr = ADDR_W'(ldc); ld_data = 8'(ldc); ldc++;
        tick();
      end
      vectors++; if (!got) begin miscompares++; $display("FAIL st_save_grant_%0d: got no save transaction expected one within 40 cycles", r); end
      vectors++; if (n != SMAX) begin miscompares++; $display("FAIL st_streak_%0d: got %0d loader transfers expected %0d", r, n, SMAX); end
      vectors++; if (sv_ack !== 1'b1) begin miscompares++; $display("FAIL st_sv_ack_%0d: got %b expected 1", r, sv_ack); end
      mem_ack = mem_req;
      ld_addr = ADDR_W'(ldc); ld_data = 8'(ldc); ldc++;
      tick();
      sv_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem_ack = mem_req;
        ld_addr = ADDR_W'(ldc); ld_data = 8'(ldc); ldc++;
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ld_we = 1'b1; ld_addr = ADDR_W'(8'h40 + i); ld_data = 8'(i);
      tick();
    end
    ld_we = 1'b0;
    vectors++; if (mem_req !== 1'b1 || fifo_level !== 3'd3) begin miscompares++; $display("FAIL rm_pre: got req=%b level=%0d expected 1 3", mem_req, fifo_level); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (mem_req !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rm_flush: got req=%b level=%0d ovf=%b busy=%b expected 0 0 0 0", mem_req, fifo_level, overflow, busy); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vectors++; if (sv_ack !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_stray: got ack=%b req=%b expected 0 0", sv_ack, mem_req); end
    sv_req = 1'b1; sv_we = 1'b0; sv_addr = 22'h001234;
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rm_sv_grant: got %b expected 1", mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0; sv_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_sv_drop: got %b expected 0", mem_req); end
    tick();
    mem_ack = 1'b0;
    vectors++; if (sv_ack !== 1'b0 || mem_req !== 1'b0 || sv_rdata !== 8'h00) begin miscompares++; $display("FAIL rm_sv_noack: got ack=%b req=%b rdata=%h expected 0 0 00", sv_ack, mem_req, sv_rdata); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic last_ack;
    int ld_pct;
    do_reset();
    last_ack = 1'b0;
    for (int i = 0; i < 800; i++) begin
      ld_pct = (i < 400) ? 25 : 80;
      reset = ($urandom_range(0, 99) == 0);
      ld_we = ($urandom_range(0, 99) < ld_pct);
      ld_addr = ADDR_W'($urandom); ld_data = 8'($urandom);
      sv_we = 1'($urandom); sv_addr = ADDR_W'($urandom); sv_wdata = 8'($urandom);
      if (!m_sv_ack) begin
        if (sv_req && last_ack) sv_req = 1'($urandom_range(0, 1));
        else if (!sv_req) sv_req = ($urandom_range(0, 5) == 0);
      end
      last_ack = m_sv_ack;
      mem_ack = m_req ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
      mem_rdata = 8'($urandom);
      tick();
      vectors++; if (mem_req !== m_req) begin miscompares++; $display("FAIL rnd_mem_req @%0d: got %b expected %b", i, mem_req, m_req); end
      vectors++; if (sv_ack !== m_sv_ack) begin miscompares++; $display("FAIL rnd_sv_ack @%0d: got %b expected %b", i, sv_ack, m_sv_ack); end
      vectors++; if (sv_rdata !== m_rdata) begin miscompares++; $display("FAIL rnd_sv_rdata @%0d: got %h expected %h", i, sv_rdata, m_rdata); end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow @%0d: got %b expected %b", i, overflow, m_ovf); end
      vectors++; if (fifo_level !== LVL_W'(m_fifo.size())) begin miscompares++; $display("FAIL rnd_level @%0d: got %0d expected %0d", i, fifo_level, m_fifo.size()); end
      vectors++; if (busy !== (m_fifo.size() != 0 || m_xfer != 0)) begin miscompares++; $display("FAIL rnd_busy @%0d: got %b expected %b", i, busy, (m_fifo.size() != 0 || m_xfer != 0)); end
      if (m_req) begin
        vectors++; if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata) begin miscompares++; $display("FAIL rnd_mem_bus @%0d: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h", i, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_overflow();
    test_save_read();
    test_starvation();
    test_reset_mid_transfer();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
